// File: rtl/seq_pattern_pkg.sv
// Shared state encoding and default sizing for the serial pattern transmitter.
// Pure declarations: no latency or flow-control behaviour of its own.
package seq_pattern_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_GAP_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_pattern_tx_shreg.sv
// Pattern load/shift register with bit-index down-counter; exposes the bit that will be on the line after this edge.
// One-cycle load-to-bit latency; no backpressure, the FSM alone decides when to load, shift or reload.
module pattern_shreg
    import seq_pattern_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic               i_reload,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_bit_nxt,
    output logic               o_last
);

    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] r_sh;
    logic [LEN_W-1:0]   r_idx;
    logic [LEN_W-1:0]   r_len_m1;
    logic [LEN_W-1:0]   w_shamt;
    logic [MAX_LEN-1:0] w_aligned;

    // Left-align so bit len-1 sits at the MSB; unused upper pattern bits fall off the top.
    assign w_shamt   = LEN_W'(MAX_LEN) - i_len;
    assign w_aligned = i_pattern << w_shamt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pat    <= '0;
            r_sh     <= '0;
            r_idx    <= '0;
            r_len_m1 <= '0;
        end else if (i_load) begin
            r_pat    <= w_aligned;
            r_sh     <= w_aligned;
            r_idx    <= i_len - 1'b1;
            r_len_m1 <= i_len - 1'b1;
        end else if (i_reload) begin
            r_sh  <= r_pat;
            r_idx <= r_len_m1;
        end else if (i_shift) begin
            r_sh  <= {r_sh[MAX_LEN-2:0], 1'b0};
            r_idx <= r_idx - 1'b1;
        end
    end

    always_comb begin
        o_bit_nxt = r_sh[MAX_LEN-1];
        if (i_load) begin
            o_bit_nxt = w_aligned[MAX_LEN-1];
        end else if (i_reload) begin
            o_bit_nxt = r_pat[MAX_LEN-1];
        end else if (i_shift) begin
            o_bit_nxt = r_sh[MAX_LEN-2];
        end
    end

    assign o_last = (r_idx == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: drives a captured word MSB-first on w with repeats and zero gaps; first bit one cycle after start.
// No backpressure: start is only sampled in IDLE, ignored while busy, and abort cancels at the next edge.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_W   = DEF_GAP_W
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [CNT_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    output logic               w,
    output logic               w_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_rep;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_w;
    logic               r_w_valid;
    logic               r_err;

    logic               w_load;
    logic               w_shift;
    logic               w_reload;
    logic               w_bit_nxt;
    logic               w_last;
    logic               w_len_bad;
    logic               w_err_nxt;
    logic               w_rep_dec;
    logic               w_gap_enter;

    assign w_len_bad = (len == '0) || (len > LEN_W'(MAX_LEN));

    pattern_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_reload  (w_reload),
        .i_pattern (pattern),
        .i_len     (len),
        .o_bit_nxt (w_bit_nxt),
        .o_last    (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_reload    = 1'b0;
        w_err_nxt   = 1'b0;
        w_rep_dec   = 1'b0;
        w_gap_enter = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_len_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    if (r_rep != '0) begin
                        w_rep_dec = 1'b1;
                        if (r_gap != '0) begin
                            w_gap_enter = 1'b1;
                            w_state_nxt = GAP;
                        end else begin
                            w_reload = 1'b1;
                        end
                    end else begin
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_shift = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_reload    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_w       <= 1'b0;
            r_w_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_w       <= (w_state_nxt == SHIFT) & w_bit_nxt;
            r_w_valid <= (w_state_nxt == SHIFT);
            r_err     <= w_err_nxt;
        end
    end

    // r_rep holds repetitions still owed after the one currently shifting out.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_rep     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_load) begin
                r_rep <= (reps == '0) ? '0 : reps - 1'b1;
                r_gap <= gap;
            end else if (w_rep_dec) begin
                r_rep <= r_rep - 1'b1;
            end
            if (w_gap_enter) begin
                r_gap_cnt <= r_gap - 1'b1;
            end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign w       = r_w;
    assign w_valid = r_w_valid;
    assign busy    = (r_state != IDLE);
    // An abort in DONE leaves at the same edge, so the pulse is withheld.
    assign done    = (r_state == DONE) & ~abort;
    assign err     = r_err;

endmodule
